// File: rtl/user_au_stream_scheduler.sv
// user_au_stream_scheduler
//   Paces audio samples from the audio interface into the LPF/HPF filter
//   cascade. Samples are released at most once per programmable sample period.
//   Samples that arrive early wait in a small FIFO. The number of samples
//   inside the cascade is capped by snooping the cascade's return handshake.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cfg_en_i                 scheduler enable
//   cfg_period_i             a tick occurs every cfg_period_i+1 cycles
//   cfg_max_inflight_i       cap on samples in the cascade (0 means 15)
//   clear_i                  clears the sticky flags and the missed-slot counter
//   in_data_i/valid_i/ready_o  sample stream from the audio interface
//   fil_data_o/valid_o/ready_i sample stream into the filter cascade
//   ret_valid_i/ret_ready_i  snooped output handshake of the cascade
//   fifo_level_o             FIFO occupancy
//   inflight_o               samples launched but not yet returned
//   missed_cnt_o             saturating count of missed sample slots
//   overrun_o                sticky: input offered while the FIFO was full
//   proto_err_o              sticky: return seen with nothing in flight
module user_au_stream_scheduler #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned Depth       = 4,
  parameter int unsigned PeriodWidth = 16,
  parameter int unsigned CntWidth    = 16,
  localparam int unsigned PtrWidth   = $clog2(Depth),
  localparam int unsigned LvlWidth   = $clog2(Depth) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_en_i,
  input  logic [PeriodWidth-1:0] cfg_period_i,
  input  logic [3:0]             cfg_max_inflight_i,
  input  logic                   clear_i,
  input  logic [DataWidth-1:0]   in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [DataWidth-1:0]   fil_data_o,
  output logic                   fil_valid_o,
  input  logic                   fil_ready_i,
  input  logic                   ret_valid_i,
  input  logic                   ret_ready_i,
  output logic [LvlWidth-1:0]    fifo_level_o,
  output logic [3:0]             inflight_o,
  output logic [CntWidth-1:0]    missed_cnt_o,
  output logic                   overrun_o,
  output logic                   proto_err_o
);

  // FIFO storage is not reset: the pointers and level define what is valid.
  logic [DataWidth-1:0]   mem_q [Depth];
  logic [PtrWidth-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LvlWidth-1:0]    level_q, level_d;

  logic [PeriodWidth-1:0] cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic                   fil_valid_q, fil_valid_d;
  logic [DataWidth-1:0]   fil_data_q, fil_data_d;
  logic [3:0]             inflight_q, inflight_d;
  logic [CntWidth-1:0]    missed_q, missed_d;
  logic                   overrun_q, overrun_d;
  logic                   proto_err_q, proto_err_d;

  logic       fifo_full, fifo_empty;
  logic       push, launch, tick, ret, missed_slot;
  logic [3:0] cap;

  assign fifo_full  = (level_q == LvlWidth'(Depth));
  assign fifo_empty = (level_q == '0);
  // Push is blocked while full. A pop in the same cycle does not free a slot.
  assign push       = in_valid_i & ~fifo_full;
  assign cap        = (cfg_max_inflight_i == 4'd0) ? 4'd15 : cfg_max_inflight_i;
  assign tick       = cfg_en_i & (cnt_q == cfg_period_i);
  // Launch only into an idle output register. This gives a 2-cycle minimum spacing.
  assign launch     = cfg_en_i & pending_q & ~fifo_empty & ~fil_valid_q &
                      (inflight_q < cap);
  assign ret        = ret_valid_i & ret_ready_i;
  // A tick that lands on an unconsumed slot is lost, unless that slot launches now.
  assign missed_slot = tick & pending_q & ~launch;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    fil_valid_d = fil_valid_q;
    fil_data_d  = fil_data_q;
    inflight_d  = inflight_q;
    missed_d    = missed_q;
    overrun_d   = overrun_q;
    proto_err_d = proto_err_q;

    // Period counter. If the period shrinks below the current count, the
    // counter free-runs through all-ones and wraps back to 0.
    if (!cfg_en_i) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PeriodWidth'(1);
    end

    if (!cfg_en_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = tick | (pending_q & ~launch);
    end

    // FIFO pointers and level
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    end
    if (launch) begin
      rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    end
    case ({push, launch})
      2'b10:   level_d = level_q + LvlWidth'(1);
      2'b01:   level_d = level_q - LvlWidth'(1);
      default: level_d = level_q;
    endcase

    // Output register: hold until the cascade accepts
    if (launch) begin
      fil_valid_d = 1'b1;
      fil_data_d  = mem_q[rd_ptr_q];
    end else if (fil_valid_q && fil_ready_i) begin
      fil_valid_d = 1'b0;
    end

    // In-flight accounting. A simultaneous launch and return cancel out.
    if (launch && !ret) begin
      inflight_d = inflight_q + 4'd1;
    end else if (!launch && ret) begin
      if (inflight_q == 4'd0) begin
        proto_err_d = 1'b1;
      end else begin
        inflight_d = inflight_q - 4'd1;
      end
    end

    if (missed_slot && (missed_q != '1)) begin
      missed_d = missed_q + CntWidth'(1);
    end

    if (in_valid_i && fifo_full) begin
      overrun_d = 1'b1;
    end

    // Clear takes priority over any set or increment in the same cycle
    if (clear_i) begin
      overrun_d   = 1'b0;
      proto_err_d = 1'b0;
      missed_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      fil_valid_q <= 1'b0;
      fil_data_q  <= '0;
      inflight_q  <= 4'd0;
      missed_q    <= '0;
      overrun_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      fil_valid_q <= fil_valid_d;
      fil_data_q  <= fil_data_d;
      inflight_q  <= inflight_d;
      missed_q    <= missed_d;
      overrun_q   <= overrun_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign in_ready_o   = ~fifo_full;
  assign fil_data_o   = fil_data_q;
  assign fil_valid_o  = fil_valid_q;
  assign fifo_level_o = level_q;
  assign inflight_o   = inflight_q;
  assign missed_cnt_o = missed_q;
  assign overrun_o    = overrun_q;
  assign proto_err_o  = proto_err_q;

endmodule
